// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM for the multicycle RV32I core. Walks each instruction
//   through fetch, decode, execute, memory and writeback, and drives the
//   ALU source muxes, ALU operation, immediate-extender select, memory port
//   and register-file enables.
//
// Parameters
//   STATE_W   width of the state register and state_o (>= 4)
//   ILL_TRAP  1: an unknown opcode parks the FSM in ERR until reset
//             0: an unknown opcode is treated as a NOP (back to FETCH)
//
// Ports
//   clk, rst_n            core clock, synchronous active-low reset
//   op, funct3, funct7b5  instruction fields from the instruction register
//   zero                  ALU zero flag, consulted in BRANCH only
//   mem_ready             memory handshake (only with MULTICYCLE_CTRL_MEMWAIT_EN)
//   PCWrite, IRWrite      PC and instruction/OldPC register enables
//   AdrSrc, MemWrite      memory address select and data write strobe
//   ResultSrc             00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA               00 PC, 01 OldPC, 10 RD1, 11 constant 0
//   ALUSrcB               00 RD2, 01 ExtImm, 10 constant 4
//   ImmSrc                000 I, 001 S, 010 B, 011 U, 100 J, 101 shift-I
//   ALUControl            0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra
//   RegWrite              register-file write enable
//   illegal               high while parked in ERR
//   state_o               current state, debug only (FETCH encodes as 0)
//
// Optional feature macro: MULTICYCLE_CTRL_MEMWAIT_EN
//   When defined, a mem_ready input is added; FETCH, MEMREAD and MEMWRITE
//   stall until it is high, and PCWrite/IRWrite/MemWrite only fire in the
//   ready cycle.
//
// Outputs are decoded from the state. Exceptions: PCWrite in BRANCH uses
// zero, and a few states look at the (stable) instruction fields.
module multicycle_ctrl #(
    parameter int STATE_W  = 4,
    parameter bit ILL_TRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    input  logic               mem_ready,
`endif
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ImmSrc,
    output logic [3:0]         ALUControl,
    output logic               RegWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // LUI and AUIPC share one state (S_UPPER) and differ only in ALUSrcA,
    // which keeps the full state set inside 16 encodings for STATE_W = 4.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR2,
        S_JALWB,
        S_UPPER,
        S_ERR
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;
    logic   br_taken;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign state_o = state_q;

    // Shared R/I ALU decode; 'alt' is funct7b5 already qualified by the caller.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = alt ? 4'd1 : 4'd0;
            3'b001:  r = 4'd7;
            3'b010:  r = 4'd5;
            3'b011:  r = 4'd6;
            3'b100:  r = 4'd4;
            3'b101:  r = alt ? 4'd9 : 4'd8;
            3'b110:  r = 4'd3;
            default: r = 4'd2;
        endcase
        return r;
    endfunction

    // Branch condition from the ALU zero flag: sub gives zero on equality,
    // slt/sltu give zero when the "less than" test is false.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:          br_taken = zero;
            3'b001:          br_taken = ~zero;
            3'b100, 3'b110:  br_taken = ~zero;
            3'b101, 3'b111:  br_taken = zero;
            default:         br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = 4'd0;
        RegWrite   = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target OldPC+imm is precomputed here; JAL needs the
                // J-format immediate for the same add.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 3'b100 : 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = ILL_TRAP ? S_ERR : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7b5);
                state_d    = S_ALUWB;
            end
            S_EXEC_I: begin
                // Instr[30] is part of the immediate except for srai, so it
                // must not turn addi into sub.
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b101 : 3'b000;
                ALUControl = alu_decode(funct3, funct7b5 && (funct3 == 3'b101));
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ImmSrc  = 3'b010;
                case (funct3[2:1])
                    2'b10:   ALUControl = 4'd5;
                    2'b11:   ALUControl = 4'd6;
                    default: ALUControl = 4'd1;
                endcase
                PCWrite = br_taken;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from DECODE while the ALU forms OldPC+4.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 3'b100;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALR2;
            end
            S_JALR2: begin
                // The datapath clears bit 0 of ALUOut on the way into PC.
                PCWrite = 1'b1;
                state_d = S_JALWB;
            end
            S_JALWB: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_UPPER: begin
                ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b011;
                state_d = S_ALUWB;
            end
            S_ERR: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A reset cycle must never commit architectural state, even if the
        // FSM was sitting in a write state when reset arrived.
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each instruction is expanded into the
//   list of per-cycle output bundles it must produce; a compare process checks
//   the DUT against that list every cycle. Reset, ERR and abort cases are
//   checked with hand-written literals.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    logic       mem_ready = 1'b1;
`endif

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
        .mem_ready  (mem_ready),
`endif
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       aluDc;
        logic       rw;
        logic       ill;
    } step_t;

    step_t expq[$];

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic [3:0] cpi;
    } stim_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU code from the instruction's mnemonic: base operation per funct3,
    // and the "alternate" form (sub, sra) is the next code up.
    function automatic logic [3:0] aluFor(input logic [2:0] f3, input logic alt);
        int base [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        int v;
        v = base[f3];
        if (alt && (f3 == 3'd0 || f3 == 3'd5)) v = v + 1;
        return 4'(v);
    endfunction

    function automatic logic branchTaken(input logic [2:0] f3, input logic z);
        case (f3)
            3'd0:       return z;
            3'd1:       return !z;
            3'd4, 3'd6: return !z;
            3'd5, 3'd7: return z;
            default:    return 1'b0;
        endcase
    endfunction

    // Expected per-cycle behaviour of one whole instruction.
    task automatic pushProgram(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        step_t s;
        s = '0; s.irw = 1; s.pcw = 1; s.sb = 2; s.res = 2; expq.push_back(s);
        s = '0; s.sa = 1; s.sb = 1; s.imm = (o == OP_JAL) ? 3'd4 : 3'd2; expq.push_back(s);
        case (o)
            OP_LOAD: begin
                s = '0; s.sa = 2; s.sb = 1; expq.push_back(s);
                s = '0; s.adr = 1; expq.push_back(s);
                s = '0; s.res = 1; s.rw = 1; expq.push_back(s);
            end
            OP_STORE: begin
                s = '0; s.sa = 2; s.sb = 1; s.imm = 1; expq.push_back(s);
                s = '0; s.adr = 1; s.mw = 1; expq.push_back(s);
            end
            OP_RTYPE: begin
                s = '0; s.sa = 2; s.alu = aluFor(f3, f7); expq.push_back(s);
                s = '0; s.rw = 1; expq.push_back(s);
            end
            OP_ITYPE: begin
                s = '0; s.sa = 2; s.sb = 1;
                s.imm = (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
                s.alu = aluFor(f3, f7 && f3 == 3'd5); expq.push_back(s);
                s = '0; s.rw = 1; expq.push_back(s);
            end
            OP_BRANCH: begin
                s = '0; s.sa = 2; s.imm = 2; s.pcw = branchTaken(f3, z);
                if (f3 == 3'd0 || f3 == 3'd1) s.alu = 1;
                else if (f3 == 3'd4 || f3 == 3'd5) s.alu = 5;
                else if (f3 == 3'd6 || f3 == 3'd7) s.alu = 6;
                else s.aluDc = 1;
                expq.push_back(s);
            end
            OP_JAL: begin
                s = '0; s.sa = 1; s.sb = 2; s.pcw = 1; s.imm = 4; expq.push_back(s);
                s = '0; s.rw = 1; expq.push_back(s);
            end
            OP_JALR: begin
                s = '0; s.sa = 2; s.sb = 1; expq.push_back(s);
                s = '0; s.pcw = 1; expq.push_back(s);
                s = '0; s.sa = 1; s.sb = 2; s.rw = 1; s.res = 2; expq.push_back(s);
            end
            OP_LUI, OP_AUIPC: begin
                s = '0; s.sa = (o == OP_LUI) ? 2'd3 : 2'd1; s.sb = 1; s.imm = 3; expq.push_back(s);
                s = '0; s.rw = 1; expq.push_back(s);
            end
            default: ;
        endcase
    endtask

    // Called in a FETCH cycle just after the clock edge; returns with the
    // DUT back in FETCH just after an edge.
    task automatic applyStimulus(input stim_t v, output int n);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
        pushProgram(v.op, v.f3, v.f7, v.z);
        n = expq.size();
        repeat (n) @(posedge clk);
        #1;
        checkOutput("queue drained", 32'(expq.size()), 32'd0);
    endtask

    task automatic stepTo(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every cycle with work queued, compare all outputs to the model.
    always @(negedge clk) begin : cmp
        step_t e;
        if (rst_n && expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("PCWrite",   32'(PCWrite),   32'(e.pcw));
            checkOutput("AdrSrc",    32'(AdrSrc),    32'(e.adr));
            checkOutput("MemWrite",  32'(MemWrite),  32'(e.mw));
            checkOutput("IRWrite",   32'(IRWrite),   32'(e.irw));
            checkOutput("ResultSrc", 32'(ResultSrc), 32'(e.res));
            checkOutput("ALUSrcA",   32'(ALUSrcA),   32'(e.sa));
            checkOutput("ALUSrcB",   32'(ALUSrcB),   32'(e.sb));
            checkOutput("ImmSrc",    32'(ImmSrc),    32'(e.imm));
            if (!e.aluDc) checkOutput("ALUControl", 32'(ALUControl), 32'(e.alu));
            checkOutput("RegWrite",  32'(RegWrite),  32'(e.rw));
            checkOutput("illegal",   32'(illegal),   32'(e.ill));
        end
    end

    stim_t prog [] = '{
        '{OP_LOAD,   3'd2, 1'b0, 1'b0, 4'd5},
        '{OP_STORE,  3'd2, 1'b0, 1'b0, 4'd4},
        '{OP_RTYPE,  3'd0, 1'b0, 1'b0, 4'd4},
        '{OP_RTYPE,  3'd0, 1'b1, 1'b0, 4'd4},
        '{OP_RTYPE,  3'd5, 1'b1, 1'b0, 4'd4},
        '{OP_RTYPE,  3'd5, 1'b0, 1'b0, 4'd4},
        '{OP_RTYPE,  3'd2, 1'b0, 1'b0, 4'd4},
        '{OP_RTYPE,  3'd6, 1'b0, 1'b0, 4'd4},
        '{OP_RTYPE,  3'd7, 1'b1, 1'b0, 4'd4},
        '{OP_ITYPE,  3'd0, 1'b1, 1'b0, 4'd4},
        '{OP_ITYPE,  3'd5, 1'b1, 1'b0, 4'd4},
        '{OP_ITYPE,  3'd1, 1'b0, 1'b0, 4'd4},
        '{OP_ITYPE,  3'd4, 1'b1, 1'b0, 4'd4},
        '{OP_ITYPE,  3'd3, 1'b0, 1'b0, 4'd4},
        '{OP_BRANCH, 3'd0, 1'b0, 1'b1, 4'd3},
        '{OP_BRANCH, 3'd0, 1'b0, 1'b0, 4'd3},
        '{OP_BRANCH, 3'd1, 1'b0, 1'b1, 4'd3},
        '{OP_BRANCH, 3'd1, 1'b0, 1'b0, 4'd3},
        '{OP_BRANCH, 3'd4, 1'b0, 1'b0, 4'd3},
        '{OP_BRANCH, 3'd5, 1'b0, 1'b0, 4'd3},
        '{OP_BRANCH, 3'd7, 1'b0, 1'b1, 4'd3},
        '{OP_BRANCH, 3'd6, 1'b0, 1'b1, 4'd3},
        '{OP_BRANCH, 3'd2, 1'b0, 1'b1, 4'd3},
        '{OP_BRANCH, 3'd3, 1'b0, 1'b0, 4'd3},
        '{OP_JAL,    3'd0, 1'b0, 1'b0, 4'd4},
        '{OP_JALR,   3'd0, 1'b0, 1'b0, 4'd5},
        '{OP_LUI,    3'd0, 1'b0, 1'b0, 4'd4},
        '{OP_AUIPC,  3'd0, 1'b0, 1'b0, 4'd4}
    };

    // Watchdog so a stuck bench still reports.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        stim_t v;

        // Reset held for two clocks; strobes stay low while reset is applied.
        rst_n = 1'b0;
        @(posedge clk); #3;
        checkOutput("reset MemWrite", 32'(MemWrite), 32'd0);
        checkOutput("reset RegWrite", 32'(RegWrite), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #3;
        checkOutput("post-reset state", 32'(state_o), 32'd0);
        checkOutput("post-reset IRWrite", 32'(IRWrite), 32'd1);
        checkOutput("post-reset PCWrite", 32'(PCWrite), 32'd1);
        checkOutput("post-reset MemWrite", 32'(MemWrite), 32'd0);
        checkOutput("post-reset RegWrite", 32'(RegWrite), 32'd0);

        foreach (prog[i]) begin
            v = prog[i];
            applyStimulus(v, n);
            checkOutput($sformatf("cpi[%0d]", i), 32'(n), 32'(v.cpi));
        end
        #3;
        checkOutput("back in FETCH", 32'(state_o), 32'd0);

        // srai and addi-with-Instr[30] literals.
        op = OP_ITYPE; funct3 = 3'd5; funct7b5 = 1'b1;
        stepTo(2); #3;
        checkOutput("srai ALUControl", 32'(ALUControl), 32'd9);
        checkOutput("srai ImmSrc", 32'(ImmSrc), 32'd5);
        stepTo(2);
        op = OP_ITYPE; funct3 = 3'd0; funct7b5 = 1'b1;
        stepTo(2); #3;
        checkOutput("addi ALUControl", 32'(ALUControl), 32'd0);
        stepTo(2); #3;

        // Unknown opcode parks in ERR until reset.
        op = 7'b0000000; funct3 = 3'd0; funct7b5 = 1'b0;
        stepTo(2);
        for (int k = 0; k < 20; k++) begin
            #3;
            checkOutput("ERR illegal", 32'(illegal), 32'd1);
            checkOutput("ERR PCWrite", 32'(PCWrite), 32'd0);
            checkOutput("ERR IRWrite", 32'(IRWrite), 32'd0);
            stepTo(1);
        end
        rst_n = 1'b0;
        stepTo(1);
        rst_n = 1'b1;
        #3;
        checkOutput("ERR reset state", 32'(state_o), 32'd0);
        checkOutput("ERR reset illegal", 32'(illegal), 32'd0);

        // Store aborted by reset in MEMADR.
        op = OP_STORE; funct3 = 3'd2;
        stepTo(1);
        stepTo(1); #3;
        checkOutput("sw MEMADR MemWrite", 32'(MemWrite), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #3;
        checkOutput("sw abort state", 32'(state_o), 32'd0);
        checkOutput("sw abort MemWrite", 32'(MemWrite), 32'd0);

        // Store caught by reset while already in MEMWRITE: the strobe is dropped.
        stepTo(3);
        checkOutput("sw MEMWRITE armed", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("sw MEMWRITE dropped", 32'(MemWrite), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #3;
        checkOutput("sw MEMWRITE reset state", 32'(state_o), 32'd0);

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
        // FETCH stalls while memory is not ready.
        op = OP_LUI;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("wait state", 32'(state_o), 32'd0);
            checkOutput("wait PCWrite", 32'(PCWrite), 32'd0);
            checkOutput("wait IRWrite", 32'(IRWrite), 32'd0);
            @(posedge clk); #4;
        end
        mem_ready = 1'b1;
        #1;
        checkOutput("ready PCWrite", 32'(PCWrite), 32'd1);
        stepTo(4); #3;
`endif

        v = prog[0];
        applyStimulus(v, n);
        checkOutput("final lw cpi", 32'(n), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
